// File: rtl/tcn_pkg.sv
// Shared types and constants for the TCN address sequencer.
// The optional configuration check is enabled with TCN_SEQ_CFG_CHECK_EN.
package tcn_pkg;

  localparam int ADDR_W = 8;
  localparam int BLK_W  = 16;
  localparam int TAP_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_UPD0 = 3'd3,
    ST_UPD1 = 3'd4
  } tcn_state_e;

  typedef struct packed {
    logic [BLK_W-1:0]  rd_bsize;
    logic [BLK_W-1:0]  wr_bsize;
    logic [ADDR_W-1:0] blocks;
    logic [TAP_W-1:0]  taps;
    logic [ADDR_W-1:0] dilation;
  } tcn_cfg_t;

  localparam int CFG_W = $bits(tcn_cfg_t);

  // A zero block count behaves as a single block.
  function automatic logic [ADDR_W-1:0] eff_blocks(input logic [ADDR_W-1:0] n);
    return (n == {ADDR_W{1'b0}}) ? {{(ADDR_W-1){1'b0}}, 1'b1} : n;
  endfunction

endpackage

// File: rtl/tcn_elem_counter.sv
// Element counter shared by the read and write phases of the sequencer.
// Counts accepted elements up to size-1; clear has priority over advance.
module tcn_elem_counter
  import tcn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [BLK_W-1:0] size,
  output logic [BLK_W-1:0] count,
  output logic             last
);

  // Element index register: cleared on phase/tap entry, steps on each accepted element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {BLK_W{1'b0}};
    end else if (clear) begin
      count <= {BLK_W{1'b0}};
    end else if (advance) begin
      count <= count + {{(BLK_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign last = (count == (size - {{(BLK_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/tcn_addr_sequencer.sv
// Address sequencer for the TCN circular activation buffer: per time step it
// walks dilated read taps, then the new output block's write words, then
// pulses update_pointer and waits one cycle for the consumer to register it.
// Optional macro TCN_SEQ_CFG_CHECK_EN adds a start-time range check and cfg_error.
module tcn_addr_sequencer
  import tcn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_W-1:0]  cfg_rd_bsize,
  input  logic [BLK_W-1:0]  cfg_wr_bsize,
  input  logic [ADDR_W-1:0] cfg_blocks,
  input  logic [TAP_W-1:0]  cfg_taps,
  input  logic [ADDR_W-1:0] cfg_dilation,
  input  logic              rd_ready,
  input  logic              wr_valid,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_enable,
  output logic              update_pointer,
  output logic              pad,
  output logic              busy,
  output logic              done
`ifdef TCN_SEQ_CFG_CHECK_EN
  ,
  output logic              cfg_error
`endif
);

  tcn_state_e                 state_r, state_next_s;
  tcn_cfg_t                   cfg_r;
  logic [TAP_W-1:0]           tap_r;
  logic [BLK_W-1:0]           elem_s, elem_size_s;
  logic                       elem_last_s, elem_adv_s, elem_clr_s;
  logic                       tap_last_s, tap_step_s, rd_done_s, wr_done_s;
  logic                       start_ok_s, cfg_bad_s, pad_s;
  logic [ADDR_W-1:0]          n_in_eff_s, n_last_s, blk_idx_s;
  logic [ADDR_W+TAP_W-1:0]    tap_off_s;
  logic [ADDR_W-1:0]          rd_base_s, wr_base_s;

  assign n_in_eff_s = eff_blocks(cfg_blocks);

`ifdef TCN_SEQ_CFG_CHECK_EN
  localparam logic [BLK_W+ADDR_W-1:0] ADDR_SPAN = {{(BLK_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  logic [BLK_W-1:0]        max_bs_s;
  logic [BLK_W+ADDR_W-1:0] chk_prod_s;
  assign max_bs_s   = (cfg_rd_bsize > cfg_wr_bsize) ? cfg_rd_bsize : cfg_wr_bsize;
  assign chk_prod_s = {{BLK_W{1'b0}}, n_in_eff_s} * {{ADDR_W{1'b0}}, max_bs_s};
  assign cfg_bad_s  = (chk_prod_s > ADDR_SPAN);

  // Sticky error flag: re-evaluated on every start taken in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_error <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      cfg_error <= cfg_bad_s;
    end else begin
      cfg_error <= cfg_error;
    end
  end
`else
  assign cfg_bad_s = 1'b0;
`endif

  assign start_ok_s = (state_r == ST_IDLE) && start && !cfg_bad_s;

  // Configuration snapshot: held for the whole step so mid-step changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_r <= {CFG_W{1'b0}};
    end else if (start_ok_s) begin
      cfg_r.rd_bsize <= cfg_rd_bsize;
      cfg_r.wr_bsize <= cfg_wr_bsize;
      cfg_r.blocks   <= n_in_eff_s;
      cfg_r.taps     <= cfg_taps;
      cfg_r.dilation <= cfg_dilation;
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // Tap geometry: tap offset in blocks is computed at full width before the pad test.
  assign n_last_s   = cfg_r.blocks - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign tap_off_s  = {{ADDR_W{1'b0}}, tap_r} * {{TAP_W{1'b0}}, cfg_r.dilation};
  assign pad_s      = (state_r == ST_RD) && (tap_off_s > {{TAP_W{1'b0}}, n_last_s});
  assign blk_idx_s  = n_last_s - tap_off_s[ADDR_W-1:0];
  // The low ADDR_W bits of a product depend only on the low ADDR_W bits of its operands.
  assign rd_base_s  = cfg_r.rd_bsize[ADDR_W-1:0] * blk_idx_s;
  assign wr_base_s  = cfg_r.wr_bsize[ADDR_W-1:0] * n_last_s;
  assign tap_last_s = (tap_r == (cfg_r.taps - {{(TAP_W-1){1'b0}}, 1'b1}));

  // Element counter control: size and advance condition depend on the phase.
  always_comb begin
    elem_size_s = {BLK_W{1'b0}};
    elem_adv_s  = 1'b0;
    case (state_r)
      ST_RD: begin
        elem_size_s = cfg_r.rd_bsize;
        elem_adv_s  = pad_s ? 1'b1 : rd_ready;
      end
      ST_WR: begin
        elem_size_s = cfg_r.wr_bsize;
        elem_adv_s  = wr_valid;
      end
      default: begin
        elem_size_s = {BLK_W{1'b0}};
        elem_adv_s  = 1'b0;
      end
    endcase
  end

  assign rd_done_s  = (state_r == ST_RD) && elem_adv_s && elem_last_s && tap_last_s;
  assign tap_step_s = (state_r == ST_RD) && elem_adv_s && elem_last_s && !tap_last_s;
  assign wr_done_s  = (state_r == ST_WR) && elem_adv_s && elem_last_s;
  assign elem_clr_s = (state_next_s != state_r) || tap_step_s;

  tcn_elem_counter u_elem (
    .clk     (clk),
    .reset   (reset),
    .clear   (elem_clr_s),
    .advance (elem_adv_s),
    .size    (elem_size_s),
    .count   (elem_s),
    .last    (elem_last_s)
  );

  // Next-state logic; empty phases are skipped straight to the next one.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if ((cfg_taps != {TAP_W{1'b0}}) && (cfg_rd_bsize != {BLK_W{1'b0}})) begin
            state_next_s = ST_RD;
          end else if (cfg_wr_bsize != {BLK_W{1'b0}}) begin
            state_next_s = ST_WR;
          end else begin
            state_next_s = ST_UPD0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_done_s) begin
          state_next_s = (cfg_r.wr_bsize != {BLK_W{1'b0}}) ? ST_WR : ST_UPD0;
        end else begin
          state_next_s = ST_RD;
        end
      end
      ST_WR: begin
        if (wr_done_s) begin
          state_next_s = ST_UPD0;
        end else begin
          state_next_s = ST_WR;
        end
      end
      ST_UPD0: state_next_s = ST_UPD1;
      ST_UPD1: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; reset aborts a step without issuing update_pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Tap index: zero outside RD, steps after the last element of each tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_r <= {TAP_W{1'b0}};
    end else if (state_r != ST_RD) begin
      tap_r <= {TAP_W{1'b0}};
    end else if (tap_step_s) begin
      tap_r <= tap_r + {{(TAP_W-1){1'b0}}, 1'b1};
    end else begin
      tap_r <= tap_r;
    end
  end

  assign rd_enable      = (state_r == ST_RD) && !pad_s && rd_ready;
  assign rd_address     = ((state_r == ST_RD) && !pad_s) ? (rd_base_s + elem_s[ADDR_W-1:0]) : {ADDR_W{1'b0}};
  assign wr_enable      = (state_r == ST_WR) && wr_valid;
  assign wr_address     = (state_r == ST_WR) ? (wr_base_s + elem_s[ADDR_W-1:0]) : {ADDR_W{1'b0}};
  assign pad            = pad_s;
  assign update_pointer = (state_r == ST_UPD0);
  assign done           = (state_r == ST_UPD1);
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tcn_addr_sequencer.sv
// Self-checking bench for tcn_addr_sequencer: directed and random time steps
// compared cycle by cycle against an expected address list built from the rules.
module tb_tcn_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_rd_bsize = 16'd0;
  logic [15:0] cfg_wr_bsize = 16'd0;
  logic [7:0]  cfg_blocks = 8'd0;
  logic [3:0]  cfg_taps = 4'd0;
  logic [7:0]  cfg_dilation = 8'd0;
  logic        rd_ready = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  rd_address, wr_address;
  logic        rd_enable, wr_enable, update_pointer, pad, busy, done;
`ifdef TCN_SEQ_CFG_CHECK_EN
  logic        cfg_error;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tcn_addr_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_rd_bsize   (cfg_rd_bsize),
    .cfg_wr_bsize   (cfg_wr_bsize),
    .cfg_blocks     (cfg_blocks),
    .cfg_taps       (cfg_taps),
    .cfg_dilation   (cfg_dilation),
    .rd_ready       (rd_ready),
    .wr_valid       (wr_valid),
    .rd_address     (rd_address),
    .rd_enable      (rd_enable),
    .wr_address     (wr_address),
    .wr_enable      (wr_enable),
    .update_pointer (update_pointer),
    .pad            (pad),
    .busy           (busy),
    .done           (done)
`ifdef TCN_SEQ_CFG_CHECK_EN
    ,
    .cfg_error      (cfg_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_enable), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_enable), 32'd0);
    chk({tag, "_upd"}, 32'(update_pointer), 32'd0);
    chk({tag, "_pad"}, 32'(pad), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_address), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_address), 32'd0);
  endtask

  function automatic bit pick(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    else if (mode == 1) return bit'(cyc % 2);
    else return bit'($urandom_range(0, 1));
  endfunction

  // One time step: expected read/write address lists come straight from the
  // block-index formula; the bench then walks them as the DUT accepts words.
  task automatic run_step(input int n, input int rbs, input int wbs, input int k, input int d,
                          input int rmode, input int wmode, input bit disturb, input bit abort);
    int  neff, td, cyc, wr_cnt, upd_phase, up_cnt, done_cnt;
    int  rdq[$];
    bit  padq[$];
    int  wrq[$];
    bit  finished;
    neff = (n == 0) ? 1 : n;
    for (int t = 0; t < k; t++) begin
      td = t * d;
      for (int e = 0; e < rbs; e++) begin
        if (td > neff - 1) begin
          rdq.push_back(0);
          padq.push_back(1'b1);
        end else begin
          rdq.push_back(((neff - 1 - td) * rbs + e) % 256);
          padq.push_back(1'b0);
        end
      end
    end
    for (int e = 0; e < wbs; e++) wrq.push_back(((neff - 1) * wbs + e) % 256);

    @(negedge clk);
    start = 1'b1;
    cfg_blocks = 8'(n); cfg_rd_bsize = 16'(rbs); cfg_wr_bsize = 16'(wbs);
    cfg_taps = 4'(k); cfg_dilation = 8'(d);
    cyc = 0; wr_cnt = 0; upd_phase = 0; up_cnt = 0; done_cnt = 0; finished = 1'b0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (disturb && (cyc == 3 || cyc == 4)) begin
        start = 1'b1;
        cfg_blocks = 8'($urandom); cfg_rd_bsize = 16'($urandom_range(1, 20));
        cfg_wr_bsize = 16'($urandom_range(1, 20)); cfg_taps = 4'($urandom);
        cfg_dilation = 8'($urandom);
      end
      rd_ready = pick(rmode, cyc);
      wr_valid = pick(wmode, cyc);
      if (abort && rdq.size() == 0 && wr_cnt == 3) begin
        reset = 1'b0;
        #1;
        chk_quiet("abort");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (i == 1) reset = 1'b1;
          #1;
          chk_quiet("post_abort");
        end
        return;
      end
      #1;
      up_cnt += int'(update_pointer);
      done_cnt += int'(done);
      if (rdq.size() > 0) begin
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_pad", 32'(pad), 32'(padq[0]));
        chk("rd_wr_en", 32'(wr_enable), 32'd0);
        chk("rd_upd", 32'(update_pointer | done), 32'd0);
        if (padq[0]) begin
          chk("pad_rd_en", 32'(rd_enable), 32'd0);
          void'(rdq.pop_front()); void'(padq.pop_front());
        end else begin
          chk("rd_en", 32'(rd_enable), 32'(rd_ready));
          chk("rd_addr", 32'(rd_address), 32'(rdq[0]));
          if (rd_ready) begin
            void'(rdq.pop_front()); void'(padq.pop_front());
          end
        end
      end else if (wrq.size() > 0) begin
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_rd_en", 32'(rd_enable | pad), 32'd0);
        chk("wr_upd", 32'(update_pointer | done), 32'd0);
        chk("wr_en", 32'(wr_enable), 32'(wr_valid));
        chk("wr_addr", 32'(wr_address), 32'(wrq[0]));
        if (wr_valid) begin
          void'(wrq.pop_front());
          wr_cnt++;
        end
      end else if (upd_phase == 0) begin
        chk("upd0_pulse", 32'(update_pointer), 32'd1);
        chk("upd0_done", 32'(done), 32'd0);
        chk("upd0_strobes", 32'(rd_enable | wr_enable | pad), 32'd0);
        upd_phase = 1;
      end else if (upd_phase == 1) begin
        chk("upd1_pulse", 32'(update_pointer), 32'd0);
        chk("upd1_done", 32'(done), 32'd1);
        chk("upd1_busy", 32'(busy), 32'd1);
        upd_phase = 2;
      end else begin
        chk_quiet("idle_after");
        finished = 1'b1;
      end
    end
    chk("step_finished", 32'(finished), 32'd1);
    chk("update_count", 32'(up_cnt), 32'd1);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("step_cycles", 32'(cyc >= 3), 32'd1);
  endtask

  initial begin
    // Reset state.
    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_quiet("after_reset");
`ifdef TCN_SEQ_CFG_CHECK_EN
    chk("cfg_error_reset", 32'(cfg_error), 32'd0);
`endif

    // Baseline: reads 24..31 then 16..23, writes 24..31.
    run_step(4, 8, 8, 2, 1, 0, 0, 1'b0, 1'b0);
    // Read handshake toggling 1010...
    run_step(4, 8, 8, 2, 1, 1, 1, 1'b0, 1'b0);
    // Dilated taps with padding: N=3, D=2 pads tap 2; D=3 pads taps 1 and 2.
    run_step(3, 4, 4, 3, 2, 0, 0, 1'b0, 1'b0);
    run_step(3, 4, 4, 3, 3, 2, 2, 1'b0, 1'b0);
    // Start and config changes during RD are ignored.
    run_step(4, 8, 8, 2, 1, 0, 0, 1'b1, 1'b0);
    // Reset during WR at element 3, then a clean step.
    run_step(4, 8, 8, 2, 1, 0, 0, 1'b0, 1'b1);
    run_step(4, 8, 8, 2, 1, 0, 0, 1'b0, 1'b0);
    // Skip cases and N=0.
    run_step(5, 4, 3, 0, 1, 0, 0, 1'b0, 1'b0);
    run_step(5, 0, 3, 2, 1, 0, 0, 1'b0, 1'b0);
    run_step(5, 4, 0, 2, 1, 0, 0, 1'b0, 1'b0);
    run_step(5, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_step(0, 3, 2, 3, 1, 2, 2, 1'b0, 1'b0);
    // Maximum taps with zero dilation, every tap reads the newest block.
    run_step(6, 2, 2, 15, 0, 0, 0, 1'b0, 1'b0);

    // Random configurations (kept within the 256-word address span).
    for (int i = 0; i < 10; i++) begin
      run_step(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 2, 2, 1'b0, 1'b0);
    end

`ifdef TCN_SEQ_CFG_CHECK_EN
    // Oversized config: 32*16 words exceed the address span.
    @(negedge clk);
    start = 1'b1; cfg_blocks = 8'd32; cfg_rd_bsize = 16'd16; cfg_wr_bsize = 16'd4;
    cfg_taps = 4'd2; cfg_dilation = 8'd1; rd_ready = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk_quiet("cfg_bad");
      chk("cfg_error_set", 32'(cfg_error), 32'd1);
    end
    run_step(4, 8, 8, 2, 1, 0, 0, 1'b0, 1'b0);
    chk("cfg_error_clear", 32'(cfg_error), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
